// File: rtl/tdm_mux_8x1.sv
// tdm_mux_8x1: registered 8:1 time-division multiplexer (serializer).
// Captures one frame of 8 lanes on load, then presents one lane per accepted
// beat with its index on {s2,s1,s0}. All outputs are registered.
// Optional feature: define TDM_MUX_PARITY_EN to add output y_par = ^y.
module tdm_mux_8x1 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [8*WIDTH-1:0] d,
    input  logic               load,
    output logic               busy,
    output logic [WIDTH-1:0]   y,
    output logic               s2,
    output logic               s1,
    output logic               s0,
    output logic               y_valid,
    input  logic               y_ready,
    output logic               frame_start,
`ifdef TDM_MUX_PARITY_EN
    output logic               y_par,
`endif
    output logic               frame_done
);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e           state_q;
    logic [2:0]       idx_q;
    logic [WIDTH-1:0] frame_q [8];

    logic [WIDTH-1:0] d_lanes [8];
    logic [2:0]       idx_next;
    logic [WIDTH-1:0] lane_next;
    logic             transfer;
    logic             last_beat;
    logic             start;
    logic             advance;
    logic             finish;

    // Split the flat frame input into lanes and decode the beat-level events.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            d_lanes[k] = d[k*WIDTH +: WIDTH];
        end
        idx_next  = idx_q + 3'd1;
        lane_next = frame_q[idx_next];
        transfer  = (state_q == StSend) && y_valid && y_ready;
        last_beat = transfer && (idx_q == 3'd7);
        // A new frame starts from idle, or back-to-back on the lane-7 transfer.
        start     = load && ((state_q == StIdle) || last_beat);
        advance   = transfer && (idx_q != 3'd7);
        finish    = last_beat && !load;
    end

    // FSM, frame storage and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= 3'd0;
            for (int k = 0; k < 8; k++) begin
                frame_q[k] <= '0;
            end
            y           <= '0;
            {s2, s1, s0} <= 3'b000;
            y_valid     <= 1'b0;
            busy        <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
`ifdef TDM_MUX_PARITY_EN
            y_par       <= 1'b0;
`endif
        end else begin
            // frame_done fires once per completed frame, even on a back-to-back restart.
            frame_done <= last_beat;
            if (start) begin
                state_q      <= StSend;
                idx_q        <= 3'd0;
                frame_q      <= d_lanes;
                y            <= d_lanes[0];
                {s2, s1, s0} <= 3'b000;
                y_valid      <= 1'b1;
                busy         <= 1'b1;
                frame_start  <= 1'b1;
`ifdef TDM_MUX_PARITY_EN
                y_par        <= ^d_lanes[0];
`endif
            end else if (advance) begin
                idx_q        <= idx_next;
                y            <= lane_next;
                {s2, s1, s0} <= idx_next;
                frame_start  <= 1'b0;
`ifdef TDM_MUX_PARITY_EN
                y_par        <= ^lane_next;
`endif
            end else if (finish) begin
                state_q      <= StIdle;
                idx_q        <= 3'd0;
                y            <= '0;
                {s2, s1, s0} <= 3'b000;
                y_valid      <= 1'b0;
                busy         <= 1'b0;
                frame_start  <= 1'b0;
`ifdef TDM_MUX_PARITY_EN
                y_par        <= 1'b0;
`endif
            end
            // Otherwise stalled or idle without load: hold everything.
        end
    end

endmodule

// File: tb/tb_tdm_mux_8x1.sv
// tb_tdm_mux_8x1: directed self-checking bench for tdm_mux_8x1 (WIDTH=1),
// plus a WIDTH=4 parity instance when TDM_MUX_PARITY_EN is defined.
module tb_tdm_mux_8x1;

    logic       clk;
    logic       rst;
    logic [7:0] d;
    logic       load;
    logic       busy;
    logic [0:0] y;
    logic       s2, s1, s0;
    logic       y_valid;
    logic       y_ready;
    logic       frame_start;
    logic       frame_done;
`ifdef TDM_MUX_PARITY_EN
    logic       y_par;
    logic [31:0] p_d;
    logic        p_load;
    logic        p_busy;
    logic [3:0]  p_y;
    logic        p_s2, p_s1, p_s0;
    logic        p_y_valid;
    logic        p_y_ready;
    logic        p_frame_start;
    logic        p_frame_done;
    logic        p_y_par;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] obs;
    assign obs = {y, s2, s1, s0, y_valid, busy, frame_start, frame_done};

    tdm_mux_8x1 #(.WIDTH(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .d           (d),
        .load        (load),
        .busy        (busy),
        .y           (y),
        .s2          (s2),
        .s1          (s1),
        .s0          (s0),
        .y_valid     (y_valid),
        .y_ready     (y_ready),
        .frame_start (frame_start),
`ifdef TDM_MUX_PARITY_EN
        .y_par       (y_par),
`endif
        .frame_done  (frame_done)
    );

`ifdef TDM_MUX_PARITY_EN
    tdm_mux_8x1 #(.WIDTH(4)) p_dut (
        .clk         (clk),
        .rst         (rst),
        .d           (p_d),
        .load        (p_load),
        .busy        (p_busy),
        .y           (p_y),
        .s2          (p_s2),
        .s1          (p_s1),
        .s0          (p_s0),
        .y_valid     (p_y_valid),
        .y_ready     (p_y_ready),
        .frame_start (p_frame_start),
        .y_par       (p_y_par),
        .frame_done  (p_frame_done)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {y, s2, s1, s0, y_valid, busy, frame_start, frame_done} for lane k of frame f.
    function automatic logic [7:0] beat(input logic [7:0] f, input int k, input logic done);
        logic [2:0] kk;
        kk = k[2:0];
        return {f[k], kk, 1'b1, 1'b1, (k == 0), done};
    endfunction

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; y_ready = 1'b0; d = 8'h00;
        repeat (2) @(negedge clk);
        n_tests++;
        if (obs !== 8'h00) begin
            n_fail++; $display("FAIL reset_outputs: got %b expected %b", obs, 8'h00);
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (obs !== 8'h00) begin
            n_fail++; $display("FAIL idle_after_reset: got %b expected %b", obs, 8'h00);
        end
    endtask

    task automatic test_basic();
        logic [7:0] f;
        f = 8'b1010_0110;
        d = f; load = 1'b1; y_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            load = 1'b0; d = 8'h00;
            n_tests++;
            if (obs !== beat(f, k, 1'b0)) begin
                n_fail++; $display("FAIL basic_beat%0d: got %b expected %b", k, obs, beat(f, k, 1'b0));
            end
        end
        @(negedge clk);
        n_tests++;
        if (obs !== 8'h01) begin
            n_fail++; $display("FAIL basic_done: got %b expected %b", obs, 8'h01);
        end
        @(negedge clk);
        n_tests++;
        if (obs !== 8'h00) begin
            n_fail++; $display("FAIL basic_done_clear: got %b expected %b", obs, 8'h00);
        end
    endtask

    task automatic test_stall();
        logic [7:0] f;
        f = 8'hC5;
        d = f; load = 1'b1; y_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            load = 1'b0;
            n_tests++;
            if (obs !== beat(f, k, 1'b0)) begin
                n_fail++; $display("FAIL stall_pre%0d: got %b expected %b", k, obs, beat(f, k, 1'b0));
            end
        end
        y_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (obs !== beat(f, 3, 1'b0)) begin
                n_fail++; $display("FAIL stall_hold%0d: got %b expected %b", i, obs, beat(f, 3, 1'b0));
            end
        end
        y_ready = 1'b1;
        for (int k = 4; k < 8; k++) begin
            @(negedge clk);
            n_tests++;
            if (obs !== beat(f, k, 1'b0)) begin
                n_fail++; $display("FAIL stall_post%0d: got %b expected %b", k, obs, beat(f, k, 1'b0));
            end
        end
        @(negedge clk);
        n_tests++;
        if (obs !== 8'h01) begin
            n_fail++; $display("FAIL stall_done: got %b expected %b", obs, 8'h01);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] f;
        logic [7:0] g;
        f = 8'h5A; g = 8'hFF;
        d = f; load = 1'b1; y_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            load = 1'b0;
            n_tests++;
            if (obs !== beat(f, k, 1'b0)) begin
                n_fail++; $display("FAIL b2b_a%0d: got %b expected %b", k, obs, beat(f, k, 1'b0));
            end
        end
        d = g; load = 1'b1;
        // First beat of the new frame coincides with the old frame's done pulse.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            load = 1'b0;
            n_tests++;
            if (obs !== beat(g, k, (k == 0))) begin
                n_fail++; $display("FAIL b2b_b%0d: got %b expected %b", k, obs, beat(g, k, (k == 0)));
            end
        end
        @(negedge clk);
        n_tests++;
        if (obs !== 8'h01) begin
            n_fail++; $display("FAIL b2b_done: got %b expected %b", obs, 8'h01);
        end
        @(negedge clk);
        n_tests++;
        if (obs !== 8'h00) begin
            n_fail++; $display("FAIL b2b_idle: got %b expected %b", obs, 8'h00);
        end
    endtask

    task automatic test_ignore_load();
        logic [7:0] f;
        f = 8'h3C;
        d = f; load = 1'b1; y_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            load = 1'b0; d = f;
            n_tests++;
            if (obs !== beat(f, k, 1'b0)) begin
                n_fail++; $display("FAIL ignore_beat%0d: got %b expected %b", k, obs, beat(f, k, 1'b0));
            end
            if (k == 2) begin
                load = 1'b1; d = 8'hC3;
            end
        end
        @(negedge clk);
        n_tests++;
        if (obs !== 8'h01) begin
            n_fail++; $display("FAIL ignore_done: got %b expected %b", obs, 8'h01);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [7:0] f;
        logic [7:0] g;
        f = 8'hA5; g = 8'h81;
        d = f; load = 1'b1; y_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            load = 1'b0;
            n_tests++;
            if (obs !== beat(f, k, 1'b0)) begin
                n_fail++; $display("FAIL rstmid_beat%0d: got %b expected %b", k, obs, beat(f, k, 1'b0));
            end
        end
        #1 rst = 1'b1;
        #1;
        n_tests++;
        if (obs !== 8'h00) begin
            n_fail++; $display("FAIL rstmid_async: got %b expected %b", obs, 8'h00);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (obs !== 8'h00) begin
            n_fail++; $display("FAIL rstmid_no_done: got %b expected %b", obs, 8'h00);
        end
        d = g; load = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            load = 1'b0;
            n_tests++;
            if (obs !== beat(g, k, 1'b0)) begin
                n_fail++; $display("FAIL rstmid_reload%0d: got %b expected %b", k, obs, beat(g, k, 1'b0));
            end
        end
        @(negedge clk);
        n_tests++;
        if (obs !== 8'h01) begin
            n_fail++; $display("FAIL rstmid_reload_done: got %b expected %b", obs, 8'h01);
        end
        @(negedge clk);
    endtask

`ifdef TDM_MUX_PARITY_EN
    task automatic test_parity();
        // lane0 = 4'b0110 (parity 0), lane3 = 4'b0111 (parity 1), other lanes 0.
        p_d = 32'h0000_7006; p_load = 1'b1; p_y_ready = 1'b1;
        @(negedge clk);
        p_load = 1'b0;
        n_tests++;
        if ({p_y, p_y_par} !== {4'b0110, 1'b0}) begin
            n_fail++; $display("FAIL parity_lane0: got %b expected %b", {p_y, p_y_par}, {4'b0110, 1'b0});
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if ({p_y, p_s2, p_s1, p_s0, p_y_par} !== {4'b0111, 3'b011, 1'b1}) begin
            n_fail++; $display("FAIL parity_lane3: got %b expected %b",
                               {p_y, p_s2, p_s1, p_s0, p_y_par}, {4'b0111, 3'b011, 1'b1});
        end
        repeat (6) @(negedge clk);
    endtask
`endif

    initial begin
`ifdef TDM_MUX_PARITY_EN
        p_d = 32'h0; p_load = 1'b0; p_y_ready = 1'b0;
`endif
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_ignore_load();
        test_reset_mid();
`ifdef TDM_MUX_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
